// File: rtl/serial_sub16_pkg.sv
// Shared definitions for the bit-serial subtractor: default width,
// FSM state encoding and the signed-overflow rule.
package serial_sub16_pkg;

    // Default operand/result width.
    localparam int WIDTH_DEF = 16;

    // FSM state codes; code 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Signed overflow of a - b: operands differ in sign and the
    // result sign differs from the minuend sign.
    function automatic logic sub_ovfl(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_sub16_full_sub1.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_sub1 (
    output logic d,
    output logic bout,
    input  logic x,
    input  logic y,
    input  logic bin
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial subtractor d = a - b, LSB first, one bit per clock.
// A single full_sub1 cell is reused every cycle; operands are shifted
// right through it and result bits are shifted in from the top.
module serial_sub16
    import serial_sub16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovfl,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] d_sh_reg;
    logic             bw_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] d_sh_next;

    full_sub1 u_cell (
        .d    (cell_d),
        .bout (cell_bout),
        .x    (a_sh_reg[0]),
        .y    (b_sh_reg[0]),
        .bin  (bw_reg)
    );

    // Result shift register: new bit enters at the MSB, everything else moves down.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_dshift
            assign d_sh_next[gi] = d_sh_reg[gi+1];
        end
    endgenerate
    assign d_sh_next[WIDTH-1] = cell_d;

    // Control FSM, bit counter, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            d_sh_reg  <= '0;
            bw_reg    <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            d         <= '0;
            borrow    <= 1'b0;
            ovfl      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Accept a new operation; DONE -> RUN needs no IDLE gap.
                        state_reg <= S_RUN;
                        busy      <= 1'b1;
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
                        bw_reg    <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                S_RUN: begin
                    // start is ignored here; only the latched operands matter.
                    d_sh_reg <= d_sh_next;
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    bw_reg   <= cell_bout;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cnt_reg   <= '0;
                        d         <= d_sh_next;
                        borrow    <= cell_bout;
                        ovfl      <= sub_ovfl(a_msb_reg, b_msb_reg, cell_d);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub16.sv
// Testbench for serial_sub16: directed vector table, randomized ops
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_serial_sub16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        borrow;
    logic        ovfl;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    serial_sub16 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .d      (d),
        .borrow (borrow),
        .ovfl   (ovfl),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        borrow;
        logic        ovfl;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                         output logic [15:0] md, output logic mbo, output logic mov);
        int sa;
        int sb;
        int r;
        sa  = int'($signed(ma));
        sb  = int'($signed(mb));
        r   = sa - sb;
        md  = 16'((int'(ma) - int'(mb)) & 32'hFFFF);
        mbo = (int'(ma) < int'(mb));
        mov = (r > 32767) || (r < -32768);
    endtask

    // Drive start with operands; returns after the accepting edge (E0).
    task automatic launch(input logic [15:0] la, input logic [15:0] lb, input bit hold);
        @(negedge clk);
        start = 1'b1;
        a     = la;
        b     = lb;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Wait for done counting edges after E0; scrambles a/b during RUN.
    // inject_at > 0 re-pulses start with a=0x1234 at that cycle.
    task automatic wait_done(input int inject_at, input bit hold,
                             output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = busy ? 1 : 0;
        while (1) begin
            if (inject_at > 0 && lat == inject_at) begin
                start = 1'b1;
                a     = 16'h1234;
            end else begin
                if (!hold) start = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
            end
            @(negedge clk);
            lat++;
            if (done) break;
            if (busy) busy_cycles++;
            if (lat >= 40) break;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", lat, 16);
        check("busy_cycles", busy_cycles, 16);
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          bc;
        logic [15:0] md;
        logic        mbo;
        logic        mov;
        logic [15:0] fa;
        logic [15:0] fb;
        bit          saw_done;

        vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
        vecs[2] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'h1D67, 16'hE38C, 16'h39DB, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_d", {16'd0, d}, 32'd0);
        check("reset_flags", {27'd0, borrow, ovfl, busy, done}, 32'd0);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b, 1'b0);
            wait_done(0, 1'b0, lat, bc);
            $display("vec %0d a=%h b=%h d=%h borrow=%b ovfl=%b lat=%0d",
                     i, vecs[i].a, vecs[i].b, d, borrow, ovfl, lat);
            check("vec_d", {16'd0, d}, {16'd0, vecs[i].d});
            check("vec_borrow", {31'd0, borrow}, {31'd0, vecs[i].borrow});
            check("vec_ovfl", {31'd0, ovfl}, {31'd0, vecs[i].ovfl});
            check("roundtrip", {16'd0, 16'(d + vecs[i].b)}, {16'd0, vecs[i].a});
        end

        // Outputs hold in IDLE.
        repeat (3) @(negedge clk);
        check("hold_d", {16'd0, d}, 32'h39DB);
        check("hold_done", {31'd0, done}, 32'd0);

        // Start re-pulsed while busy is ignored.
        launch(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(5, 1'b0, lat, bc);
        $display("busy_restart d=%h borrow=%b lat=%0d", d, borrow, lat);
        check("ign_d", {16'd0, d}, 32'h0000);
        check("ign_borrow", {31'd0, borrow}, 32'd0);

        // Randomized ops against the model.
        for (int i = 0; i < 30; i++) begin
            fa = 16'($urandom);
            fb = 16'($urandom);
            if (i == 0) fb = fa;
            model(fa, fb, md, mbo, mov);
            launch(fa, fb, 1'b0);
            wait_done(0, 1'b0, lat, bc);
            $display("rand a=%h b=%h d=%h borrow=%b ovfl=%b", fa, fb, d, borrow, ovfl);
            check("rand_d", {16'd0, d}, {16'd0, md});
            check("rand_borrow", {31'd0, borrow}, {31'd0, mbo});
            check("rand_ovfl", {31'd0, ovfl}, {31'd0, mov});
        end

        // Known non-zero result before the abort test.
        launch(16'h0005, 16'h0003, 1'b0);
        wait_done(0, 1'b0, lat, bc);
        check("pre_abort_d", {16'd0, d}, 32'h0002);

        // Reset mid-RUN aborts with no done pulse.
        launch(16'h8000, 16'h0001, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("abort busy=%b done=%b d=%h", busy, done, d);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_d", {16'd0, d}, 32'd0);
        check("abort_flags", {29'd0, borrow, ovfl, done}, 32'd0);
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);

        // Back-to-back: start held high across DONE.
        launch(16'h1000, 16'h0001, 1'b1);
        wait_done(0, 1'b1, lat, bc);
        check("b2b_first_d", {16'd0, d}, 32'h0FFF);
        a = 16'h0001;
        b = 16'h0002;
        @(negedge clk);
        start = 1'b0;
        $display("b2b second accept busy=%b done=%b", busy, done);
        check("b2b_no_idle", {30'd0, busy, done}, 32'd2);
        wait_done(0, 1'b0, lat, bc);
        $display("b2b second d=%h borrow=%b ovfl=%b lat=%0d", d, borrow, ovfl, lat);
        check("b2b_second_d", {16'd0, d}, 32'hFFFF);
        check("b2b_second_borrow", {31'd0, borrow}, 32'd1);
        check("b2b_second_ovfl", {31'd0, ovfl}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
